// File: rtl/mem_ctrl_if.sv
// Request/response and RAM bus bundle for mem_ctrl.
// slave = controller view, master = IF/MEM/RAM side.
interface mem_ctrl_if #(
  parameter int ADDR_LEN = 32,
  parameter int DATA_LEN = 32
);
  logic                inst_needed_from_IF;
  logic [ADDR_LEN-1:0] inst_addr_from_IF;
  logic [DATA_LEN-1:0] inst_data_to_IF;
  logic                inst_rdy_to_IF;
  logic                inst_busy_to_IF;

  logic                data_needed_from_MEM;
  logic                data_we_from_MEM;
  logic [1:0]          data_size_from_MEM;
  logic [ADDR_LEN-1:0] data_addr_from_MEM;
  logic [DATA_LEN-1:0] data_wdata_from_MEM;
  logic [DATA_LEN-1:0] data_rdata_to_MEM;
  logic                data_rdy_to_MEM;
  logic                data_busy_to_MEM;

  logic [7:0]          ram_din;
  logic [7:0]          ram_dout;
  logic [ADDR_LEN-1:0] ram_a;
  logic                ram_wr;

  modport slave (
    input  inst_needed_from_IF,
    input  inst_addr_from_IF,
    output inst_data_to_IF,
    output inst_rdy_to_IF,
    output inst_busy_to_IF,
    input  data_needed_from_MEM,
    input  data_we_from_MEM,
    input  data_size_from_MEM,
    input  data_addr_from_MEM,
    input  data_wdata_from_MEM,
    output data_rdata_to_MEM,
    output data_rdy_to_MEM,
    output data_busy_to_MEM,
    input  ram_din,
    output ram_dout,
    output ram_a,
    output ram_wr
  );

  modport master (
    output inst_needed_from_IF,
    output inst_addr_from_IF,
    input  inst_data_to_IF,
    input  inst_rdy_to_IF,
    input  inst_busy_to_IF,
    output data_needed_from_MEM,
    output data_we_from_MEM,
    output data_size_from_MEM,
    output data_addr_from_MEM,
    output data_wdata_from_MEM,
    input  data_rdata_to_MEM,
    input  data_rdy_to_MEM,
    input  data_busy_to_MEM,
    output ram_din,
    input  ram_dout,
    input  ram_a,
    input  ram_wr
  );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller arbitrating IF fetches and
// MEM loads/stores onto a single byte-wide RAM port.
module mem_ctrl #(
  parameter int ADDR_LEN = 32,
  parameter int DATA_LEN = 32
) (
  input logic       clk,
  input logic       rst,
  mem_ctrl_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE, INST_RD, DATA_RD, DATA_WR, DONE
  } state_t;

  state_t              r_state;
  logic [2:0]          r_cnt;
  logic [2:0]          r_n;
  logic                r_own_inst;
  logic                r_starve;
  logic [ADDR_LEN-1:0] r_addr;
  logic [DATA_LEN-1:0] r_wdata;
  logic [DATA_LEN-1:0] r_buf;
  logic [DATA_LEN-1:0] r_inst_data;
  logic [DATA_LEN-1:0] r_data_rdata;
  logic [ADDR_LEN-1:0] r_ram_a;
  logic [7:0]          r_ram_dout;
  logic                r_ram_wr;
  logic                r_inst_rdy;
  logic                r_data_rdy;

  logic [2:0]          w_n_req;
  logic                w_grant_data;
  logic                w_grant_inst;
  logic [2:0]          w_cnt_inc;
  logic [1:0]          w_cap_idx;
  logic [ADDR_LEN-1:0] w_next_a;
  logic [7:0]          w_next_byte;
  logic [DATA_LEN-1:0] w_buf_next;

  assign w_grant_data = bus.data_needed_from_MEM
                     && !(bus.inst_needed_from_IF && r_starve);
  assign w_grant_inst = bus.inst_needed_from_IF && !w_grant_data;
  assign w_cnt_inc    = r_cnt + 3'd1;
  assign w_cap_idx    = r_cnt[1:0] - 2'd1;
  assign w_next_a     = r_addr + ADDR_LEN'(w_cnt_inc);
  assign w_next_byte  = r_wdata[{w_cnt_inc[1:0], 3'b000} +: 8];

  // Decode request size into a byte count.
  always_comb begin
    w_n_req = 3'd4;
    case (bus.data_size_from_MEM)
      2'b00:   w_n_req = 3'd1;
      2'b01:   w_n_req = 3'd2;
      default: w_n_req = 3'd4;
    endcase
  end

  // Merge the byte arriving from RAM into the assembly buffer.
  always_comb begin
    w_buf_next = r_buf;
    if (r_cnt != 3'd0) begin
      w_buf_next[{w_cap_idx, 3'b000} +: 8] = bus.ram_din;
    end
  end

  // Main FSM: arbitrate in IDLE, stream bytes, pulse rdy in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_n          <= '0;
      r_own_inst   <= 1'b0;
      r_starve     <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_buf        <= '0;
      r_inst_data  <= '0;
      r_data_rdata <= '0;
      r_ram_a      <= '0;
      r_ram_dout   <= '0;
      r_ram_wr     <= 1'b0;
      r_inst_rdy   <= 1'b0;
      r_data_rdy   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_cnt <= '0;
          r_buf <= '0;
          if (w_grant_data) begin
            r_own_inst <= 1'b0;
            r_starve   <= bus.inst_needed_from_IF;
            r_addr     <= bus.data_addr_from_MEM;
            r_wdata    <= bus.data_wdata_from_MEM;
            r_n        <= w_n_req;
            r_ram_a    <= bus.data_addr_from_MEM;
            if (bus.data_we_from_MEM) begin
              r_state    <= DATA_WR;
              r_ram_wr   <= 1'b1;
              r_ram_dout <= bus.data_wdata_from_MEM[7:0];
            end else begin
              r_state <= DATA_RD;
            end
          end else if (w_grant_inst) begin
            r_own_inst <= 1'b1;
            r_starve   <= 1'b0;
            r_addr     <= bus.inst_addr_from_IF;
            r_n        <= 3'd4;
            r_ram_a    <= bus.inst_addr_from_IF;
            r_state    <= INST_RD;
          end else begin
            r_starve <= 1'b0;
          end
        end
        INST_RD, DATA_RD: begin
          r_cnt   <= w_cnt_inc;
          r_buf   <= w_buf_next;
          r_ram_a <= (w_cnt_inc < r_n) ? w_next_a : '0;
          if (r_cnt == r_n) begin
            r_state <= DONE;
            if (r_own_inst) begin
              r_inst_rdy  <= 1'b1;
              r_inst_data <= w_buf_next;
            end else begin
              r_data_rdy   <= 1'b1;
              r_data_rdata <= w_buf_next;
            end
          end
        end
        DATA_WR: begin
          if (w_cnt_inc < r_n) begin
            r_cnt      <= w_cnt_inc;
            r_ram_a    <= w_next_a;
            r_ram_dout <= w_next_byte;
          end else begin
            r_state      <= DONE;
            r_ram_wr     <= 1'b0;
            r_ram_a      <= '0;
            r_ram_dout   <= '0;
            r_data_rdy   <= 1'b1;
            r_data_rdata <= '0;
          end
        end
        DONE: begin
          r_state    <= IDLE;
          r_inst_rdy <= 1'b0;
          r_data_rdy <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.inst_data_to_IF   = r_inst_data;
  assign bus.inst_rdy_to_IF    = r_inst_rdy;
  assign bus.inst_busy_to_IF   = (r_state != IDLE) && !r_inst_rdy;
  assign bus.data_rdata_to_MEM = r_data_rdata;
  assign bus.data_rdy_to_MEM   = r_data_rdy;
  assign bus.data_busy_to_MEM  = (r_state != IDLE) && !r_data_rdy;
  assign bus.ram_a             = r_ram_a;
  assign bus.ram_dout          = r_ram_dout;
  assign bus.ram_wr            = r_ram_wr;
endmodule
